// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared definitions for the node / layer / classifier blocks:
//               scan state encoding and the node output word width.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  // Width of one node output word as produced by the node and layer blocks
  localparam int DATA_W = 32;

  // Classifier scan states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/layer_argmax.sv
`default_nettype none
// ============================================================================
// Module      : layer_argmax
// Description : Snapshots N_IN node outputs, scans them one per cycle and
//               returns the index/value of the largest entry through a
//               valid/ready handshake. Ties resolve to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_argmax #(
  parameter int N_IN   = 16,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic [DATA_W-1:0]      out_max,
  output logic                   out_none
);

  import nn_pkg::*;

  // Index of the final entry; reaching it ends the scan
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(N_IN - 1);
  // Entry 0 seeds the running best, so the scan starts at entry 1
  localparam logic [IDX_W-1:0] C_FIRST_IDX = IDX_W'(1);

  state_t              r_state;
  state_t              w_next_state;

  logic [DATA_W-1:0]   r_snap [N_IN];
  logic [IDX_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_best_val;
  logic [IDX_W-1:0]    r_best_idx;

  logic [IDX_W-1:0]    r_out_idx;
  logic [DATA_W-1:0]   r_out_max;
  logic                r_out_none;

  logic                w_accept;
  logic                w_scan;
  logic                w_last;
  logic [DATA_W-1:0]   w_cand;
  logic                w_take;
  logic [DATA_W-1:0]   w_sel_val;
  logic [IDX_W-1:0]    w_sel_idx;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_scan   = (r_state == SCAN);
  assign w_last   = w_scan && (r_cnt == C_LAST_IDX);

  // Compare/select: strictly-greater replacement keeps the earliest index on ties
  assign w_cand    = r_snap[r_cnt];
  assign w_take    = (w_cand > r_best_val);
  assign w_sel_val = w_take ? w_cand : r_best_val;
  assign w_sel_idx = w_take ? r_cnt  : r_best_idx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake flags, decoded only from the registered state
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (r_cnt == C_LAST_IDX) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Snapshot capture plus running best value/index and scan counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_IN; k++) begin
        r_snap[k] <= '0;
      end
      r_cnt      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < N_IN; k++) begin
        r_snap[k] <= in_data[k*DATA_W +: DATA_W];
      end
      r_best_val <= in_data[0 +: DATA_W];
      r_best_idx <= '0;
      r_cnt      <= C_FIRST_IDX;
    end else if (w_scan) begin
      r_best_val <= w_sel_val;
      r_best_idx <= w_sel_idx;
      if (!w_last) begin
        r_cnt <= r_cnt + C_FIRST_IDX;
      end
    end
  end

  // Result registers, loaded with the outcome of the final compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_idx  <= '0;
      r_out_max  <= '0;
      r_out_none <= 1'b0;
    end else if (w_last) begin
      r_out_idx  <= w_sel_idx;
      r_out_max  <= w_sel_val;
      r_out_none <= (w_sel_val == '0);
    end
  end

  assign out_idx  = r_out_idx;
  assign out_max  = r_out_max;
  assign out_none = r_out_none;

endmodule : layer_argmax
`default_nettype wire

// File: tb/tb_layer_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_argmax
// Description : Self-checking bench for layer_argmax. A reference model
//               computes the argmax of each accepted snapshot and the
//               expected handshake timing; a compare process checks the DUT
//               every cycle, and directed tests pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_argmax;

  localparam int N_IN   = 16;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_idx;
  logic [DATA_W-1:0]      out_max;
  logic                   out_none;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] ent [N_IN];

  layer_argmax #(
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Plain argmax over an array: first strictly-largest entry wins
  function automatic void ref_argmax(input logic [N_IN*DATA_W-1:0] d,
                                     output logic [IDX_W-1:0] idx,
                                     output logic [DATA_W-1:0] mx);
    idx = '0;
    mx  = d[0 +: DATA_W];
    for (int k = 1; k < N_IN; k++) begin
      if (d[k*DATA_W +: DATA_W] > mx) begin
        mx  = d[k*DATA_W +: DATA_W];
        idx = IDX_W'(k);
      end
    end
  endfunction

  // m_mode: 0 waiting for a snapshot, 1 busy, 2 result presented
  int                m_mode = 0;
  int                m_left = 0;
  logic [IDX_W-1:0]  m_idx  = '0;
  logic [DATA_W-1:0] m_max  = '0;
  logic              m_none = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
             ref_argmax(in_data, m_idx, m_max);
             m_none = (m_max == 0);
             m_left = N_IN - 1;
             m_mode = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) m_mode = 2;
           end
        2: if (out_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_mode == 0)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_mode == 2)});
      if (m_mode == 2) begin
        chk("out_idx", {28'd0, out_idx}, {28'd0, m_idx});
        chk("out_max", out_max, m_max);
        chk("out_none", {31'd0, out_none}, {31'd0, m_none});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N_IN*DATA_W-1:0] pack_ent();
    logic [N_IN*DATA_W-1:0] p;
    for (int k = 0; k < N_IN; k++) p[k*DATA_W +: DATA_W] = ent[k];
    return p;
  endfunction

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int k = 0; k < N_IN; k++) ent[k] = v;
  endtask

  // Offer ent[], wait for the result, optionally stall and pulse in_valid,
  // check literal results, then complete the handshake.
  task automatic do_snap(input string tag, input int exp_idx,
                         input logic [DATA_W-1:0] exp_max, input logic exp_none,
                         input int hold, input bit pulse);
    int  wait_c;
    int  lat;
    bit  ok;
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(posedge clk); #1;
      wait_c++;
    end
    if (!in_ready) begin
      chk({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    in_data  = pack_ent();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      ok = out_valid;
    end
    chk({tag, "_latency"}, lat, N_IN - 1);
    if (!ok) return;
    for (int k = 0; k < hold; k++) begin
      if (pulse && k == 5) begin
        fill(32'd9);
        ent[4]   = 32'd60000;
        in_data  = pack_ent();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_idx"}, {28'd0, out_idx}, exp_idx);
    chk({tag, "_max"}, out_max, exp_max);
    chk({tag, "_none"}, {31'd0, out_none}, {31'd0, exp_none});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("rst_out_max", out_max, 32'd0);
    chk("rst_out_none", {31'd0, out_none}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Distinct values, peak at entry 7
    for (int k = 0; k < N_IN; k++) ent[k] = 32'(k * 10);
    ent[7] = 32'd5000;
    do_snap("distinct", 7, 32'd5000, 1'b0, 0, 1'b0);

    // Tie between entries 3 and 12
    fill(32'd100);
    ent[3]  = 32'h0000_FFFF;
    ent[12] = 32'h0000_FFFF;
    do_snap("tie", 3, 32'h0000_FFFF, 1'b0, 0, 1'b0);

    // All zero
    fill(32'd0);
    do_snap("zero", 0, 32'd0, 1'b1, 0, 1'b0);

    // Back-pressure with an in_valid pulse during DONE, then a second snapshot
    for (int k = 0; k < N_IN; k++) ent[k] = 32'(2000 - k * 3);
    do_snap("bp1", 0, 32'd2000, 1'b0, 20, 1'b1);
    fill(32'd5);
    ent[10] = 32'd777;
    do_snap("bp2", 10, 32'd777, 1'b0, 0, 1'b0);

    // Maximum at the last index
    fill(32'd0);
    ent[15] = 32'd1;
    do_snap("last", 15, 32'd1, 1'b0, 0, 1'b0);

    // Upper bits compared unsigned, no masking
    fill(32'h0000_FFFF);
    ent[5] = 32'h8000_0000;
    ent[9] = 32'h7FFF_FFFF;
    do_snap("upper", 5, 32'h8000_0000, 1'b0, 3, 1'b0);

    // Reset mid-SCAN discards the scan
    for (int k = 0; k < N_IN; k++) ent[k] = 32'(k + 1);
    in_data  = pack_ent();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("midrst_out_max", out_max, 32'd0);
    chk("midrst_out_none", {31'd0, out_none}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready_next", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);

    // Recovery after reset
    fill(32'd3);
    ent[2] = 32'd4;
    do_snap("recover", 2, 32'd4, 1'b0, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_layer_argmax
`default_nettype wire
